dibit_byte_packer: RTL and testbench
====================================

Name: dibit_byte_packer

Overview:
- Downstream consumer of the 2-bit memory-mux output stream.
- Collects consecutive 2-bit words (dibits) into one NUM_DIBITS*2-bit word and presents it on a valid/ready output interface.
- Double-buffered (accumulator plus output register), so a full word can wait for the sink while the next word starts filling.
- Feeds the byte-wide stages that follow the mux in the datapath.

Parameters:
- NUM_DIBITS, 4, number of dibits per output word; output width W = 2*NUM_DIBITS; legal range 2..8.
- MSB_FIRST, 1, 1 = first accepted dibit lands in data_out[W-1:W-2]; 0 = first dibit lands in data_out[1:0].

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  data_in holds a dibit this cycle.
- data_in  input  2  incoming dibit (the mux data_out).
- flush  input  1  one-cycle pulse: close the partial word, zero-padded.
- ready_in  output  1  packer can accept a dibit this cycle.
- valid_out  output  1  data_out holds a completed word.
- data_out  output  W  completed word.
- ready_out  input  1  sink accepts data_out this cycle.
- word_count  output  8  number of words delivered (handshakes completed); wraps 255 -> 0.

Behaviour:
- Reset at the rising edge with reset=1:
  - ready_in=1, valid_out=0, data_out=0, word_count=0.
  - Accumulator cleared, fill count acc_cnt=0.
  - Reset wins over every other input; a partial word or an undelivered output word is discarded.
- Accept rule: a dibit is accepted when valid_in && ready_in at the edge; acc_cnt increments.
- ready_in = (acc_cnt != NUM_DIBITS), a registered-state decode; no combinational path from ready_out.
- Placement: the dibit with index i (0 = first of the word) goes to bits [W-1-2i : W-2-2i] when MSB_FIRST=1, or to bits [2i+1 : 2i] when MSB_FIRST=0.
- Completion: a word completes at the edge that accepts dibit NUM_DIBITS-1, or at a flush edge with 1 <= acc_cnt < NUM_DIBITS.
- Flush padding: unfilled positions are 0.
- Flush with acc_cnt=0 is ignored.
- Flush and valid_in in the same accepting cycle: the dibit is placed first, then padding applies. If that dibit is the last one, it is a normal completion.
- Output register is "free" when valid_out=0, or when valid_out && ready_out (draining this cycle).
- Completed word with a free output register:
  - Word moves to data_out at the same edge; valid_out=1 in the next cycle.
  - acc_cnt=0. Latency: one edge from the last dibit to valid_out.
- Completed word with an occupied output register:
  - Accumulator holds the word, acc_cnt=NUM_DIBITS, so ready_in=0.
  - At the first edge where valid_out && ready_out, the held word moves to data_out and valid_out stays 1.
  - acc_cnt=0 and ready_in=1 in the following cycle.
  - A flush-completed word waits the same way.
- Output hold: data_out and valid_out are stable while valid_out && !ready_out.
- Drain with nothing pending: valid_out && ready_out and no completed word pending -> valid_out=0 next cycle; data_out keeps its last value.
- word_count increments by 1 on every valid_out && ready_out edge.
- Throughput: one dibit per cycle sustained when ready_out=1; no bubbles at word boundaries.
- State machine, derived from {acc_cnt, valid_out}:
  - FILL (acc_cnt < N): accepts input.
  - HOLD (acc_cnt = N, valid_out=1): stalls input; returns to FILL on drain.
  - Plus the output register states EMPTY and FULL.
- Dibits with valid_in=1 while ready_in=0 are not consumed; the source must hold them.

Test Plan:
- Defaults, ready_out=1; dibits 11,00,10,01 on 4 consecutive cycles -> valid_out=1 one cycle after the 4th, data_out=8'hC9, word_count 0->1.
- MSB_FIRST=0, same stream -> data_out=8'h63.
- Dibits 10,11 then a flush pulse -> data_out=8'hB0. A later flush with acc_cnt=0 produces no word.
- ready_out=0, stream 8 dibits (C9 then 8'h1B = 00,01,10,11) -> data_out holds C9 and ready_in=0 after the 8th dibit. Raise ready_out for 2 cycles -> C9 then 1B delivered, word_count=2, then valid_out=0.
- reset=1 after 3 dibits, with a word pending at the output -> next cycle valid_out=0, word_count=0, ready_in=1. A new stream 01,01,01,01 -> 8'h55 with no stale bits.
- Continuous 12 dibits with ready_out=1 -> 3 words on consecutive word slots, ready_in never low, word_count=3. Run 256 words -> word_count wraps to 0.

Source files
------------

// File: rtl/dibit_byte_packer.sv
// Packs consecutive 2-bit dibits into a 2*NUM_DIBITS-bit word behind a valid/ready output.
// Double-buffered: one word may wait in the accumulator while the output register is occupied.
module dibit_byte_packer #(
  parameter int NUM_DIBITS = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [1:0]                data_in,
  input  logic                      flush,
  output logic                      ready_in,
  output logic                      valid_out,
  output logic [2*NUM_DIBITS-1:0]   data_out,
  input  logic                      ready_out,
  output logic [7:0]                word_count
);

  localparam int unsigned N        = NUM_DIBITS;
  localparam int unsigned W        = 2 * NUM_DIBITS;
  localparam logic [3:0]  CNT_FULL = 4'(NUM_DIBITS);

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

  out_state_t   r_out_state, w_out_state_nxt;
  logic [W-1:0] r_acc, w_acc_placed, w_acc_nxt;
  logic [3:0]   r_acc_cnt, w_cnt_placed, w_cnt_nxt;
  logic [W-1:0] r_data_out, w_data_nxt;
  logic [7:0]   r_word_count;

  logic w_ready_in;
  logic w_accept;
  logic w_drain;
  logic w_free;
  logic w_word_done;

  assign w_ready_in = (r_acc_cnt != CNT_FULL);
  assign w_accept   = valid_in & w_ready_in;
  assign w_drain    = (r_out_state == OUT_FULL) & ready_out;
  assign w_free     = (r_out_state == OUT_EMPTY) | ready_out;

  always_comb begin
    w_acc_placed = r_acc;
    if (w_accept) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (r_acc_cnt == 4'(i)) begin
          if (MSB_FIRST) w_acc_placed[W-1-2*i -: 2] = data_in;
          else           w_acc_placed[2*i +: 2]     = data_in;
        end
      end
    end
    w_cnt_placed = r_acc_cnt + {3'b000, w_accept};
  end

  // Unfilled positions are already zero because the accumulator is cleared on every
  // hand-off, so a flush only has to close the word; the new dibit is placed first.
  always_comb begin
    w_word_done = (w_accept && (w_cnt_placed == CNT_FULL)) ||
                  (flush && w_ready_in && (w_cnt_placed != 4'd0));

    w_acc_nxt       = w_acc_placed;
    w_cnt_nxt       = w_cnt_placed;
    w_data_nxt      = r_data_out;
    w_out_state_nxt = r_out_state;

    if (w_word_done) begin
      if (w_free) begin
        w_data_nxt      = w_acc_placed;
        w_out_state_nxt = OUT_FULL;
        w_acc_nxt       = '0;
        w_cnt_nxt       = '0;
      end else begin
        w_cnt_nxt = CNT_FULL;
      end
    end else if (!w_ready_in && w_drain) begin
      w_data_nxt      = r_acc;
      w_out_state_nxt = OUT_FULL;
      w_acc_nxt       = '0;
      w_cnt_nxt       = '0;
    end else if (w_drain) begin
      w_out_state_nxt = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_state  <= OUT_EMPTY;
      r_acc        <= '0;
      r_acc_cnt    <= '0;
      r_data_out   <= '0;
      r_word_count <= '0;
    end else begin
      r_out_state  <= w_out_state_nxt;
      r_acc        <= w_acc_nxt;
      r_acc_cnt    <= w_cnt_nxt;
      r_data_out   <= w_data_nxt;
      r_word_count <= r_word_count + {7'd0, w_drain};
    end
  end

  assign ready_in   = w_ready_in;
  assign valid_out  = (r_out_state == OUT_FULL);
  assign data_out   = r_data_out;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_dibit_byte_packer.sv
// Directed bench for dibit_byte_packer: MSB-first and LSB-first instances share one stimulus.
module tb_dibit_byte_packer;

  logic       clk;
  logic       reset;
  logic       valid_in;
  logic [1:0] data_in;
  logic       flush;
  logic       ready_out;

  logic       ready_in_m, valid_out_m;
  logic [7:0] data_out_m, wc_m;
  logic       ready_in_l, valid_out_l;
  logic [7:0] data_out_l, wc_l;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  dibit_byte_packer #(.NUM_DIBITS(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .flush(flush),
    .ready_in(ready_in_m), .valid_out(valid_out_m), .data_out(data_out_m),
    .ready_out(ready_out), .word_count(wc_m)
  );

  dibit_byte_packer #(.NUM_DIBITS(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .flush(flush),
    .ready_in(ready_in_l), .valid_out(valid_out_l), .data_out(data_out_l),
    .ready_out(ready_out), .word_count(wc_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d);
    valid_in = 1'b1;
    data_in  = d;
    tick();
  endtask

  function automatic logic [7:0] rev_dibits(input logic [7:0] b);
    return {b[1:0], b[3:2], b[5:4], b[7:6]};
  endfunction

  logic [7:0] words [3];
  logic [7:0] b;
  logic       ready_seen_low;

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = 2'b00; flush = 1'b0; ready_out = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_ready_in", 32'(ready_in_m), 32'd1);
    check("rst_valid_out", 32'(valid_out_m), 32'd0);
    check("rst_data_out", 32'(data_out_m), 32'd0);
    check("rst_word_count", 32'(wc_m), 32'd0);

    // basic word, both orderings
    send(2'b11); send(2'b00); send(2'b10);
    check("t1_not_early", 32'(valid_out_m), 32'd0);
    send(2'b01);
    valid_in = 1'b0;
    check("t1_valid", 32'(valid_out_m), 32'd1);
    check("t1_msb_data", 32'(data_out_m), 32'hC9);
    check("t1_lsb_data", 32'(data_out_l), 32'h63);
    check("t1_wc_before", 32'(wc_m), 32'd0);
    check("t1_ready_in", 32'(ready_in_m), 32'd1);
    tick();
    check("t1_wc_after", 32'(wc_m), 32'd1);
    check("t1_drained", 32'(valid_out_m), 32'd0);
    check("t1_data_kept", 32'(data_out_m), 32'hC9);

    // flush of a partial word
    send(2'b10); send(2'b11);
    valid_in = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_valid", 32'(valid_out_m), 32'd1);
    check("t3_msb_data", 32'(data_out_m), 32'hB0);
    check("t3_lsb_data", 32'(data_out_l), 32'h0E);
    tick();
    check("t3_wc", 32'(wc_m), 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_empty_flush", 32'(valid_out_m), 32'd0);
    tick();
    check("t3_empty_flush2", 32'(valid_out_m), 32'd0);
    check("t3_wc_same", 32'(wc_m), 32'd2);

    // back-pressure: second word waits in the accumulator
    ready_out = 1'b0;
    send(2'b11); send(2'b00); send(2'b10); send(2'b01);
    send(2'b00); send(2'b01); send(2'b10); send(2'b11);
    valid_in = 1'b0;
    check("t4_valid", 32'(valid_out_m), 32'd1);
    check("t4_hold_c9", 32'(data_out_m), 32'hC9);
    check("t4_ready_low", 32'(ready_in_m), 32'd0);
    tick();
    check("t4_stable", 32'(data_out_m), 32'hC9);
    check("t4_wc_stalled", 32'(wc_m), 32'd2);
    ready_out = 1'b1;
    tick();
    check("t4_second", 32'(data_out_m), 32'h1B);
    check("t4_second_lsb", 32'(data_out_l), 32'hE4);
    check("t4_valid2", 32'(valid_out_m), 32'd1);
    check("t4_ready_back", 32'(ready_in_m), 32'd1);
    check("t4_wc3", 32'(wc_m), 32'd3);
    tick();
    check("t4_wc4", 32'(wc_m), 32'd4);
    check("t4_idle", 32'(valid_out_m), 32'd0);

    // reset discards both a pending output word and a partial word
    ready_out = 1'b0;
    send(2'b11); send(2'b00); send(2'b10); send(2'b01);
    send(2'b01); send(2'b10); send(2'b11);
    valid_in = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_valid", 32'(valid_out_m), 32'd0);
    check("t5_wc", 32'(wc_m), 32'd0);
    check("t5_ready_in", 32'(ready_in_m), 32'd1);
    check("t5_data_zero", 32'(data_out_m), 32'd0);
    ready_out = 1'b1;
    send(2'b01); send(2'b01); send(2'b01); send(2'b01);
    valid_in = 1'b0;
    check("t5_msb_55", 32'(data_out_m), 32'h55);
    check("t5_lsb_55", 32'(data_out_l), 32'h55);
    tick();
    check("t5_wc1", 32'(wc_m), 32'd1);

    // continuous stream: no bubbles at word boundaries
    words[0] = 8'h1B; words[1] = 8'hE4; words[2] = 8'h3C;
    ready_seen_low = 1'b0;
    for (int w = 0; w < 3; w++) begin
      b = words[w];
      for (int j = 0; j < 4; j++) begin
        if (!ready_in_m) ready_seen_low = 1'b1;
        send(b[7:6]);
        b = b << 2;
      end
      check($sformatf("t6_valid%0d", w), 32'(valid_out_m), 32'd1);
      check($sformatf("t6_msb%0d", w), 32'(data_out_m), 32'(words[w]));
      check($sformatf("t6_lsb%0d", w), 32'(data_out_l), 32'(rev_dibits(words[w])));
    end
    valid_in = 1'b0;
    tick();
    check("t6_ready_never_low", 32'(ready_seen_low), 32'd0);
    check("t6_wc4", 32'(wc_m), 32'd4);

    // 256 words wrap the counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      send(2'(k));
      if (k == 1020) check("t7_wc255", 32'(wc_m), 32'd255);
    end
    valid_in = 1'b0;
    tick();
    check("t7_wrap", 32'(wc_m), 32'd0);
    check("t7_lsb_wrap", 32'(wc_l), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
